wb_demux_4: RTL and testbench

//   Wishbone 1-master-to-4-slave address demultiplexer; the slave-side counterpart of the 4-port arbiter.

---
 rtl/wb_demux_pkg.sv | 15 +
 rtl/wb_addr_decode.sv | 33 +++
 rtl/wb_demux_4.sv | 192 +++++++++++++++++++
 tb/tb_wb_demux_4.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_demux_pkg.sv
// rtl/wb_demux_pkg.sv - shared FSM encodings, port count and decode result type for wb_demux_4
package wb_demux_pkg;

  localparam int NUM_PORTS = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_ERR    = 2'd2;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } decode_t;

endpackage

// File: rtl/wb_addr_decode.sv
// rtl/wb_addr_decode.sv - combinational base/mask priority decode of the master address
module wb_addr_decode
  import wb_demux_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] S0_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0] S0_MASK    = '0,
  parameter logic [ADDR_WIDTH-1:0] S1_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0] S1_MASK    = '0,
  parameter logic [ADDR_WIDTH-1:0] S2_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0] S2_MASK    = '0,
  parameter logic [ADDR_WIDTH-1:0] S3_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0] S3_MASK    = '0
) (
  input  logic [ADDR_WIDTH-1:0] adr_i,
  output decode_t               dec_o
);

  localparam logic [ADDR_WIDTH-1:0] BASE [NUM_PORTS] = '{S0_ADDR, S1_ADDR, S2_ADDR, S3_ADDR};
  localparam logic [ADDR_WIDTH-1:0] MASK [NUM_PORTS] = '{S0_MASK, S1_MASK, S2_MASK, S3_MASK};

  // Scan from the highest index down so the lowest matching window is the last one written.
  always_comb begin
    dec_o = '0;
    for (int n = NUM_PORTS - 1; n >= 0; n--) begin
      if ((MASK[n] != '0) && ((adr_i & MASK[n]) == (BASE[n] & MASK[n]))) begin
        dec_o.hit = 1'b1;
        dec_o.idx = 2'(n);
      end
    end
  end

endmodule

// File: rtl/wb_demux_4.sv
// rtl/wb_demux_4.sv - Wishbone 1-master to 4-slave address demultiplexer; WB_DEMUX_TIMEOUT_EN adds a stall timeout
module wb_demux_4
  import wb_demux_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] WBS0_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0] WBS0_MASK      = '0,
  parameter logic [ADDR_WIDTH-1:0] WBS1_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0] WBS1_MASK      = '0,
  parameter logic [ADDR_WIDTH-1:0] WBS2_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0] WBS2_MASK      = '0,
  parameter logic [ADDR_WIDTH-1:0] WBS3_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0] WBS3_MASK      = '0,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  input  logic                    wbm_cyc_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]   wbs0_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs0_dat_o,
  output logic                    wbs0_we_o,
  output logic [SELECT_WIDTH-1:0] wbs0_sel_o,
  output logic                    wbs0_stb_o,
  output logic                    wbs0_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wbs0_dat_i,
  input  logic                    wbs0_ack_i,
  input  logic                    wbs0_err_i,
  input  logic                    wbs0_rty_i,
  output logic [ADDR_WIDTH-1:0]   wbs1_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs1_dat_o,
  output logic                    wbs1_we_o,
  output logic [SELECT_WIDTH-1:0] wbs1_sel_o,
  output logic                    wbs1_stb_o,
  output logic                    wbs1_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wbs1_dat_i,
  input  logic                    wbs1_ack_i,
  input  logic                    wbs1_err_i,
  input  logic                    wbs1_rty_i,
  output logic [ADDR_WIDTH-1:0]   wbs2_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs2_dat_o,
  output logic                    wbs2_we_o,
  output logic [SELECT_WIDTH-1:0] wbs2_sel_o,
  output logic                    wbs2_stb_o,
  output logic                    wbs2_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wbs2_dat_i,
  input  logic                    wbs2_ack_i,
  input  logic                    wbs2_err_i,
  input  logic                    wbs2_rty_i,
  output logic [ADDR_WIDTH-1:0]   wbs3_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs3_dat_o,
  output logic                    wbs3_we_o,
  output logic [SELECT_WIDTH-1:0] wbs3_sel_o,
  output logic                    wbs3_stb_o,
  output logic                    wbs3_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wbs3_dat_i,
  input  logic                    wbs3_ack_i,
  input  logic                    wbs3_err_i,
  input  logic                    wbs3_rty_i
);

  logic [DATA_WIDTH-1:0] s_dat [NUM_PORTS];
  logic [NUM_PORTS-1:0]  s_ack, s_err, s_rty, s_stb, s_cyc;
  logic [1:0]            state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  logic                  term;
  decode_t               dec;

  assign s_dat = '{wbs0_dat_i, wbs1_dat_i, wbs2_dat_i, wbs3_dat_i};
  assign s_ack = {wbs3_ack_i, wbs2_ack_i, wbs1_ack_i, wbs0_ack_i};
  assign s_err = {wbs3_err_i, wbs2_err_i, wbs1_err_i, wbs0_err_i};
  assign s_rty = {wbs3_rty_i, wbs2_rty_i, wbs1_rty_i, wbs0_rty_i};

  assign {wbs3_stb_o, wbs2_stb_o, wbs1_stb_o, wbs0_stb_o} = s_stb;
  assign {wbs3_cyc_o, wbs2_cyc_o, wbs1_cyc_o, wbs0_cyc_o} = s_cyc;

  // Address, data, we and sel fan out to every slave; only stb/cyc qualify the target.
  assign wbs0_adr_o = wbm_adr_i;
  assign wbs1_adr_o = wbm_adr_i;
  assign wbs2_adr_o = wbm_adr_i;
  assign wbs3_adr_o = wbm_adr_i;
  assign wbs0_dat_o = wbm_dat_i;
  assign wbs1_dat_o = wbm_dat_i;
  assign wbs2_dat_o = wbm_dat_i;
  assign wbs3_dat_o = wbm_dat_i;
  assign wbs0_we_o  = wbm_we_i;
  assign wbs1_we_o  = wbm_we_i;
  assign wbs2_we_o  = wbm_we_i;
  assign wbs3_we_o  = wbm_we_i;
  assign wbs0_sel_o = wbm_sel_i;
  assign wbs1_sel_o = wbm_sel_i;
  assign wbs2_sel_o = wbm_sel_i;
  assign wbs3_sel_o = wbm_sel_i;

  wb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .S0_ADDR    (WBS0_ADDR), .S0_MASK (WBS0_MASK),
    .S1_ADDR    (WBS1_ADDR), .S1_MASK (WBS1_MASK),
    .S2_ADDR    (WBS2_ADDR), .S2_MASK (WBS2_MASK),
    .S3_ADDR    (WBS3_ADDR), .S3_MASK (WBS3_MASK)
  ) u_decode (
    .adr_i (wbm_adr_i),
    .dec_o (dec)
  );

  assign term = s_ack[sel_q] | s_err[sel_q] | s_rty[sel_q];

`ifdef WB_DEMUX_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]            cnt_q, cnt_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    s_stb     = '0;
    s_cyc     = '0;
    wbm_dat_o = '0;
    wbm_ack_o = 1'b0;
    wbm_err_o = 1'b0;
    wbm_rty_o = 1'b0;
`ifdef WB_DEMUX_TIMEOUT_EN
    cnt_d     = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (dec.hit) begin
            sel_d   = dec.idx;
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ACTIVE: begin
        s_cyc[sel_q] = wbm_cyc_i;
        s_stb[sel_q] = wbm_stb_i;
        wbm_dat_o    = s_dat[sel_q];
        wbm_ack_o    = s_ack[sel_q];
        wbm_err_o    = s_err[sel_q];
        wbm_rty_o    = s_rty[sel_q];
        // Slave termination is checked before the timeout so a last-cycle ack still wins.
        if (!wbm_cyc_i || term) begin
          state_d = ST_IDLE;
        end
`ifdef WB_DEMUX_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_ERR: begin
        wbm_err_o = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
`ifdef WB_DEMUX_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
`ifdef WB_DEMUX_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_demux_4.sv
// tb/tb_wb_demux_4.sv - directed vector bench for wb_demux_4; timeout sequence runs when WB_DEMUX_TIMEOUT_EN is defined
module tb_wb_demux_4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_adr, m_wdat;
  logic        m_we, m_stb, m_cyc;
  logic [3:0]  m_sel;
  logic [31:0] m_rdat;
  logic        m_ack, m_err, m_rty;
  logic [31:0] s_adr [4];
  logic [31:0] s_wdat [4];
  logic [3:0]  s_we;
  logic [3:0]  s_sel [4];
  logic [3:0]  s_stb, s_cyc;
  logic [31:0] s_rdat [4];
  logic [3:0]  s_ack, s_err, s_rty;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  wb_demux_4 #(
    .DATA_WIDTH (32), .ADDR_WIDTH (32),
    .WBS0_ADDR (32'h0000_0000), .WBS0_MASK (32'hF000_0000),
    .WBS1_ADDR (32'h1000_0000), .WBS1_MASK (32'hF000_0000),
    .WBS2_ADDR (32'h2000_0000), .WBS2_MASK (32'hF000_0000),
    .WBS3_ADDR (32'h3000_0000), .WBS3_MASK (32'hF000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk (clk), .rst (rst),
    .wbm_adr_i (m_adr), .wbm_dat_i (m_wdat), .wbm_we_i (m_we), .wbm_sel_i (m_sel),
    .wbm_stb_i (m_stb), .wbm_cyc_i (m_cyc),
    .wbm_dat_o (m_rdat), .wbm_ack_o (m_ack), .wbm_err_o (m_err), .wbm_rty_o (m_rty),
    .wbs0_adr_o (s_adr[0]), .wbs0_dat_o (s_wdat[0]), .wbs0_we_o (s_we[0]), .wbs0_sel_o (s_sel[0]),
    .wbs0_stb_o (s_stb[0]), .wbs0_cyc_o (s_cyc[0]), .wbs0_dat_i (s_rdat[0]),
    .wbs0_ack_i (s_ack[0]), .wbs0_err_i (s_err[0]), .wbs0_rty_i (s_rty[0]),
    .wbs1_adr_o (s_adr[1]), .wbs1_dat_o (s_wdat[1]), .wbs1_we_o (s_we[1]), .wbs1_sel_o (s_sel[1]),
    .wbs1_stb_o (s_stb[1]), .wbs1_cyc_o (s_cyc[1]), .wbs1_dat_i (s_rdat[1]),
    .wbs1_ack_i (s_ack[1]), .wbs1_err_i (s_err[1]), .wbs1_rty_i (s_rty[1]),
    .wbs2_adr_o (s_adr[2]), .wbs2_dat_o (s_wdat[2]), .wbs2_we_o (s_we[2]), .wbs2_sel_o (s_sel[2]),
    .wbs2_stb_o (s_stb[2]), .wbs2_cyc_o (s_cyc[2]), .wbs2_dat_i (s_rdat[2]),
    .wbs2_ack_i (s_ack[2]), .wbs2_err_i (s_err[2]), .wbs2_rty_i (s_rty[2]),
    .wbs3_adr_o (s_adr[3]), .wbs3_dat_o (s_wdat[3]), .wbs3_we_o (s_we[3]), .wbs3_sel_o (s_sel[3]),
    .wbs3_stb_o (s_stb[3]), .wbs3_cyc_o (s_cyc[3]), .wbs3_dat_i (s_rdat[3]),
    .wbs3_ack_i (s_ack[3]), .wbs3_err_i (s_err[3]), .wbs3_rty_i (s_rty[3])
  );

  typedef struct {
    string       name;
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          slv;       // responding slave, ignored on a miss
    int          wait_cyc;  // ACTIVE cycles before the slave terminates
    logic [2:0]  resp;      // {rty, err, ack} driven by the slave
    logic [31:0] rdat;
    logic [3:0]  exp_stb;   // one-hot strobe expected while ACTIVE, 0 for a miss
    logic [2:0]  exp_term;  // {rty, err, ack} expected at the master
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slaves();
    s_ack = '0; s_err = '0; s_rty = '0;
  endtask

  task automatic master_start(input logic [31:0] adr);
    m_adr = adr; m_cyc = 1'b1; m_stb = 1'b1;
  endtask

  task automatic master_stop();
    m_cyc = 1'b0; m_stb = 1'b0;
  endtask

  function automatic logic [2:0] term();
    return {m_rty, m_err, m_ack};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"rd_s1_wait2", 32'h1000_0004, 1'b0, 32'h0, 4'hF, 1, 2, 3'b001, 32'hDEAD_BEEF, 4'b0010, 3'b001, 32'hDEAD_BEEF};
    vecs[1] = '{"wr_s3",       32'h3000_0010, 1'b1, 32'hA5A5_A5A5, 4'hF, 3, 0, 3'b001, 32'h0, 4'b1000, 3'b001, 32'h0};
    vecs[2] = '{"miss",        32'h8000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 3'b000, 32'h0, 4'b0000, 3'b010, 32'h0};
    vecs[3] = '{"s2_err",      32'h2000_0000, 1'b0, 32'h0, 4'h3, 2, 1, 3'b010, 32'h0000_1234, 4'b0100, 3'b010, 32'h0000_1234};
    vecs[4] = '{"s0_rty",      32'h0000_0100, 1'b1, 32'h5555_0000, 4'hC, 0, 0, 3'b100, 32'hCAFE_0000, 4'b0001, 3'b100, 32'hCAFE_0000};
    vecs[5] = '{"s1_top_edge", 32'h1FFF_FFFC, 1'b0, 32'h0, 4'hF, 1, 1, 3'b001, 32'h0BAD_F00D, 4'b0010, 3'b001, 32'h0BAD_F00D};

    rst = 1'b1;
    m_adr = '0; m_wdat = '0; m_we = 1'b0; m_sel = '0;
    master_stop();
    clear_slaves();
    s_rdat[0] = 32'h1111_1111; s_rdat[1] = 32'h2222_2222;
    s_rdat[2] = 32'h3333_3333; s_rdat[3] = 32'h4444_4444;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_stb", {56'h0, s_stb, s_cyc}, 64'h0);
    chk("reset_term", 64'(term()), 64'h0);
    chk("reset_dat_zero", 64'(m_rdat), 64'h0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      m_we = v.we; m_wdat = v.wdat; m_sel = v.sel;
      master_start(v.adr);
      #1;
      chk({v.name, "_idle_no_stb"}, 64'(s_stb), 64'h0);
      step();
      if (v.exp_stb != 4'b0) begin
        for (int w = 0; w < v.wait_cyc; w++) begin
          chk({v.name, "_wait_stb"}, 64'(s_stb), 64'(v.exp_stb));
          chk({v.name, "_wait_term"}, 64'(term()), 64'h0);
          step();
        end
        {s_rty[v.slv], s_err[v.slv], s_ack[v.slv]} = v.resp;
        s_rdat[v.slv] = v.rdat;
        #1;
        chk({v.name, "_stb"}, {56'h0, s_stb, s_cyc}, {56'h0, v.exp_stb, v.exp_stb});
        chk({v.name, "_term"}, 64'(term()), 64'(v.exp_term));
        chk({v.name, "_rdat"}, 64'(m_rdat), 64'(v.exp_dat));
        chk({v.name, "_bcast"}, {s_adr[v.slv], s_wdat[v.slv]}, {v.adr, v.wdat});
        chk({v.name, "_we_sel"}, {59'h0, s_we[v.slv], s_sel[v.slv]}, {59'h0, v.we, v.sel});
        master_stop();
        step();
        clear_slaves();
        #1;
        chk({v.name, "_after_stb"}, 64'(s_stb), 64'h0);
        chk({v.name, "_after_term"}, 64'(term()), 64'h0);
        chk({v.name, "_after_dat"}, 64'(m_rdat), 64'h0);
      end else begin
        chk({v.name, "_stb"}, {56'h0, s_stb, s_cyc}, 64'h0);
        chk({v.name, "_term"}, 64'(term()), 64'(v.exp_term));
        chk({v.name, "_rdat"}, 64'(m_rdat), 64'(v.exp_dat));
        master_stop();
        step();
        chk({v.name, "_err_one_cycle"}, 64'(term()), 64'h0);
      end
    end

    // S2 never responds: bounded wait in the timeout build, indefinite wait otherwise.
    m_we = 1'b0;
    master_start(32'h2000_0000);
    step();
`ifdef WB_DEMUX_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      chk("to_stb_high", {56'h0, s_stb, s_cyc}, {56'h0, 4'b0100, 4'b0100});
      chk("to_no_term", 64'(term()), 64'h0);
      step();
    end
    chk("to_stb_dropped", {56'h0, s_stb, s_cyc}, 64'h0);
    chk("to_err", 64'(term()), 64'h2);
    master_stop();
    step();
    chk("to_err_one_cycle", 64'(term()), 64'h0);
`else
    for (int c = 0; c < 8; c++) begin
      chk("stall_stb_high", 64'(s_stb), 64'h4);
      chk("stall_no_term", 64'(term()), 64'h0);
      step();
    end
    master_stop();
    step();
    chk("stall_abort_stb", 64'(s_stb), 64'h0);
`endif

    // S0 acks in the cycle the timeout would fire; a stray S1 ack is ignored.
    master_start(32'h0000_0040);
    step();
    s_ack[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("lim_stray_ack_ignored", 64'(term()), 64'h0);
      chk("lim_stb0", 64'(s_stb), 64'h1);
      step();
    end
    s_ack[0] = 1'b1;
    s_rdat[0] = 32'h0F0F_0F0F;
    #1;
    chk("lim_ack_wins", 64'(term()), 64'h1);
    chk("lim_dat", 64'(m_rdat), 64'h0F0F_0F0F);
    master_stop();
    step();
    clear_slaves();
    #1;
    chk("lim_no_err_after", 64'(term()), 64'h0);
    chk("lim_idle_stb", 64'(s_stb), 64'h0);

    // Master abandons the cycle mid-transfer.
    master_start(32'h3000_0000);
    step();
    chk("abort_stb3", 64'(s_stb), 64'h8);
    step();
    master_stop();
    step();
    chk("abort_strobes_low", {56'h0, s_stb, s_cyc}, 64'h0);
    chk("abort_no_term", 64'(term()), 64'h0);
    s_ack[3] = 1'b1;
    #1;
    chk("abort_late_ack_ignored", 64'(term()), 64'h0);
    clear_slaves();

    // Reset during ACTIVE discards the pending response.
    master_start(32'h1000_0000);
    step();
    chk("rst_mid_stb1", 64'(s_stb), 64'h2);
    rst = 1'b1;
    step();
    s_ack[1] = 1'b1;
    #1;
    chk("rst_mid_strobes_low", {56'h0, s_stb, s_cyc}, 64'h0);
    chk("rst_mid_no_term", 64'(term()), 64'h0);
    master_stop();
    rst = 1'b0;
    step();
    clear_slaves();
    chk("rst_mid_idle", 64'(s_stb), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
